// File: rtl/msg_asm_if.sv
// Word-in / packet-out bundle between the UART receiver, the assembler and the
// command FIFO. The assembler sits on the slave side.
interface msg_asm_if #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4
);
  logic [WORD_SIZE-1:0]                  data_in;
  logic                                  data_in_valid;
  logic                                  fifo_full;
  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out;
  logic                                  data_out_req;
  logic                                  overrun;
  logic                                  timeout_err;

  modport master (
    output data_in, data_in_valid, fifo_full,
    input  data_out, data_out_req, overrun, timeout_err
  );

  modport slave (
    input  data_in, data_in_valid, fifo_full,
    output data_out, data_out_req, overrun, timeout_err
  );
endinterface

// File: rtl/msg_asm.sv
// Packs WORDS_PER_PACKET UART words (word 0 in the LSBs) into one packet for the
// command FIFO; one packet can wait for FIFO space while the next is assembled.
module msg_asm #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter int TIMEOUT_CYCLES   = 100000
) (
  input  logic     clk,
  input  logic     reset,
  msg_asm_if.slave bus
);

  localparam int PKT_W = WORD_SIZE * WORDS_PER_PACKET;
  localparam int CTR_W = $clog2(WORDS_PER_PACKET + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int BUF_W = (WORDS_PER_PACKET > 1) ? WORD_SIZE * (WORDS_PER_PACKET - 1)
                                                : WORD_SIZE;
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(WORDS_PER_PACKET - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [PKT_W-1:0] data_out_q, data_out_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             last_word;
  logic             complete;
  logic             fifo_write;
  logic [PKT_W-1:0] packet;

  assign last_word  = (ctr_q == LAST_IDX);
  assign complete   = bus.data_in_valid & last_word;
  assign fifo_write = pending_q & ~bus.fifo_full;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    packet = '0;
    for (int i = 0; i < WORDS_PER_PACKET - 1; i++) begin
      packet[i*WORD_SIZE +: WORD_SIZE] = buf_q[i*WORD_SIZE +: WORD_SIZE];
    end
    packet[PKT_W-1 -: WORD_SIZE] = bus.data_in;
  end

  always_comb begin
    ctr_d         = ctr_q;
    buf_d         = buf_q;
    timer_d       = timer_q;
    data_out_d    = data_out_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    timeout_err_d = 1'b0;

    if (bus.data_in_valid) begin
      if (last_word) begin
        ctr_d = '0;
      end else begin
        ctr_d = ctr_q + CTR_W'(1);
        for (int i = 0; i < WORDS_PER_PACKET - 1; i++) begin
          if (ctr_q == CTR_W'(i)) buf_d[i*WORD_SIZE +: WORD_SIZE] = bus.data_in;
        end
      end
    end

    // A completion on the write edge refills the output slot instead of freeing it.
    if (complete && (!pending_q || fifo_write)) begin
      data_out_d = packet;
      pending_d  = 1'b1;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (fifo_write) begin
      pending_d = 1'b0;
    end

    if (TIMEOUT_CYCLES == 0 || bus.data_in_valid || ctr_q == '0) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      timer_d       = '0;
      ctr_d         = '0;
      timeout_err_d = 1'b1;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q         <= '0;
      timer_q       <= '0;
      // NOTE: the word buffer is cleared on reset although its contents are never read stale.
      buf_q         <= '0;
      data_out_q    <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ctr_q         <= ctr_d;
      timer_q       <= timer_d;
      buf_q         <= buf_d;
      data_out_q    <= data_out_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_out_req = fifo_write;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
